multicycle_ctrl: RTL

//  Main sequencer for the multicycle RV32I core: per-instruction FSM driving the shared ALU, memory, register

---
 rtl/multicycle_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : multicycle_ctrl
//  Brief   : Per-instruction sequencer for the multicycle RV32I core
//            (lw, sw, R-type, I-type ALU, beq, jal) with memory stall handshake.
//  Revision: 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       imm_src,
  output logic             reg_write,
  output logic             illegal_instr,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state;
  state_t     next_state;
  logic       wb_en;
  logic       op_known;
  logic       retire;
  logic [2:0] funct_alu;

  // Opcodes the sequencer knows how to execute.
  always_comb begin
    op_known = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: op_known = 1'b1;
      default:                                  op_known = 1'b0;
    endcase
  end

  // Register-register subtract only when both op[5] and funct7[5] are set.
  always_comb begin
    funct_alu = ALU_ADD;
    case (funct3)
      3'b000:  funct_alu = ({op[5], funct7b5} == 2'b11) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECR;
          OP_I:         next_state = EXECI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    next_state = FETCH;
      MEMWRITE: next_state = mem_ready ? FETCH : MEMWRITE;
      EXECR:    next_state = ALUWB;
      EXECI:    next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BEQ:      next_state = FETCH;
      JAL:      next_state = ALUWB;
      default:  next_state = FETCH;
    endcase
  end

  // JAL -> ALUWB is not a retirement; the following ALUWB -> FETCH edge is.
  assign retire = (state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                  ((state == MEMWRITE) && mem_ready);

  // Datapath selects are registered from the state being entered, so they are
  // glitch-free Moore outputs of the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      retired     <= '0;
      adr_src     <= 1'b0;
      result_src  <= 2'b10;
      alu_src_a   <= 2'b00;
      alu_src_b   <= 2'b10;
      alu_control <= ALU_ADD;
      wb_en       <= 1'b0;
    end else begin
      state <= next_state;
      if (retire) begin
        retired <= retired + RET_W'(1);
      end
      adr_src     <= 1'b0;
      result_src  <= 2'b00;
      alu_src_a   <= 2'b00;
      alu_src_b   <= 2'b00;
      alu_control <= ALU_ADD;
      wb_en       <= 1'b0;
      case (next_state)
        FETCH: begin
          result_src <= 2'b10;
          alu_src_b  <= 2'b10;
        end
        DECODE: begin
          alu_src_a <= 2'b01;
          alu_src_b <= 2'b01;
        end
        MEMADR: begin
          alu_src_a <= 2'b10;
          alu_src_b <= 2'b01;
        end
        MEMREAD:  adr_src <= 1'b1;
        MEMWB: begin
          result_src <= 2'b01;
          wb_en      <= 1'b1;
        end
        MEMWRITE: adr_src <= 1'b1;
        EXECR: begin
          alu_src_a   <= 2'b10;
          alu_control <= funct_alu;
        end
        EXECI: begin
          alu_src_a   <= 2'b10;
          alu_src_b   <= 2'b01;
          alu_control <= funct_alu;
        end
        ALUWB:    wb_en <= 1'b1;
        BEQ: begin
          alu_src_a   <= 2'b10;
          alu_control <= ALU_SUB;
        end
        JAL: begin
          alu_src_a <= 2'b01;
          alu_src_b <= 2'b10;
        end
        default: begin
          result_src <= 2'b10;
          alu_src_b  <= 2'b10;
        end
      endcase
    end
  end

  // Architectural enables are suppressed while reset is high so an abandoned
  // instruction can never commit.
  always_comb begin
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    if (!reset) begin
      ir_write      = (state == FETCH) && mem_ready;
      pc_write      = ((state == FETCH) && mem_ready) ||
                      ((state == BEQ) && zero) ||
                      (state == JAL);
      mem_write     = (state == MEMWRITE);
      reg_write     = wb_en;
      illegal_instr = (state == DECODE) && !op_known;
    end
  end

endmodule
`default_nettype wire
